// File: rtl/count_disp_pkg.sv
// Shared types and constants for the count display scanner.
// No logic; state encoding, segment font and blanking code only.
// Imported by the scanner top and the segment decoder.
package count_disp_pkg;

  // Scan sequence: units lit, gap, tens lit, gap (gap before ON0 is the frame boundary).
  typedef enum logic [1:0] {
    ON0    = 2'd0,
    BLANK0 = 2'd1,
    ON1    = 2'd2,
    BLANK1 = 2'd3
  } disp_state_t;

  // Active-high segment font for digits 0-9, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_CODE [0:9] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

  // Active-high "all segments dark".
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // True for the two states in which a digit is lit.
  function automatic logic is_on_state(input disp_state_t s);
    return (s == ON0) || (s == ON1);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit-to-segment decoder, active-high output, with a blank override.
// Purely combinational, zero cycles of latency.
// No flow control; out-of-range digits (10-15) decode dark.
module seg7_decode
  import count_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] code
);

  // Look up the font unless the caller asks for a dark digit.
  always_comb begin
    code = SEG_OFF;
    if (!blank && (digit <= 4'd9)) begin
      code = SEG_CODE[digit];
    end
  end

endmodule

// File: rtl/count_seg_scanner.sv
// Shows a 4-bit count as two decimal digits on a multiplexed 2-digit 7-seg display.
// an/seg are registered from the next-state decode: they change on the same edge as the state.
// No backpressure; count_in/hold are sampled only on the frame boundary (BLANK1 -> ON0).
module count_seg_scanner
  import count_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] count_in,
  input  logic       hold,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  // Phase counter must reach the larger of the two dwell lengths minus one.
  localparam int MAX_DWELL = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW        = $clog2(MAX_DWELL);

  localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  // Physical "all dark" level on the segment pins.
  localparam logic [6:0] SEG_DARK = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  disp_state_t   state;
  disp_state_t   state_nxt;
  logic [CW-1:0] phase_cnt;
  logic          phase_end;
  logic          boundary;

  logic [3:0]    snapshot;
  logic [3:0]    snap_nxt;
  logic          tens_nxt;
  logic [3:0]    units_nxt;

  logic [3:0]    dec_digit;
  logic          dec_blank;
  logic [6:0]    dec_code;
  logic [1:0]    an_nxt;
  logic [6:0]    seg_nxt;

  // State register and phase counter; the counter restarts on every state change.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= BLANK1;
      phase_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + CW'(1);
      end
    end
  end

  // Next-state: leave each state when its dwell length has elapsed.
  always_comb begin
    phase_end = is_on_state(state) ? (phase_cnt == ON_LAST) : (phase_cnt == BLANK_LAST);
    state_nxt = state;
    case (state)
      ON0:     if (phase_end) state_nxt = BLANK0;
      BLANK0:  if (phase_end) state_nxt = ON1;
      ON1:     if (phase_end) state_nxt = BLANK1;
      BLANK1:  if (phase_end) state_nxt = ON0;
      default: state_nxt = BLANK1;
    endcase
    boundary = (state == BLANK1) && phase_end;
  end

  // Value to be displayed from the next edge on; the units digit lit on the
  // boundary edge must already reflect the freshly captured count.
  always_comb begin
    snap_nxt  = (boundary && !hold) ? count_in : snapshot;
    tens_nxt  = (snap_nxt >= 4'd10);
    units_nxt = tens_nxt ? (snap_nxt - 4'd10) : snap_nxt;
  end

  // Output decode from the next state: which digit to light and what to show on it.
  always_comb begin
    an_nxt    = 2'b11;
    dec_digit = units_nxt;
    dec_blank = 1'b1;
    case (state_nxt)
      ON0: begin
        an_nxt    = 2'b10;
        dec_digit = units_nxt;
        dec_blank = 1'b0;
      end
      ON1: begin
        an_nxt    = 2'b01;
        dec_digit = {3'b000, tens_nxt};
        dec_blank = (LZ_BLANK != 0) && !tens_nxt;
      end
      default: begin
        an_nxt    = 2'b11;
        dec_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_decode (
    .digit (dec_digit),
    .blank (dec_blank),
    .code  (dec_code)
  );

  // Apply pin polarity after the shared decoder.
  always_comb begin
    seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~dec_code : dec_code;
  end

  // Snapshot and registered display outputs; the frame pulse marks the boundary edge.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      snapshot   <= 4'd0;
      an         <= 2'b11;
      seg        <= SEG_DARK;
      frame_done <= 1'b0;
    end else begin
      snapshot   <= snap_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_count_seg_scanner.sv
// Directed bench for count_seg_scanner with a 12-cycle frame (REFRESH_DIV=4, BLANK_CYC=2).
// A second instance covers active-high segments with leading-zero blanking off.
// Outputs are sampled 1 time unit after each rising edge.
module tb_count_seg_scanner;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] count_in;
  logic       hold;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  logic       clear2;
  logic [3:0] count2;
  logic       hold2;
  logic [6:0] seg2;
  logic [1:0] an2;
  logic       frame_done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_seg_scanner #(
    .REFRESH_DIV(4), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .clear(clear), .count_in(count_in), .hold(hold),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  count_seg_scanner #(
    .REFRESH_DIV(4), .BLANK_CYC(2), .SEG_ACTIVE_LOW(0), .LZ_BLANK(0)
  ) dut2 (
    .clk(clk), .clear(clear2), .count_in(count2), .hold(hold2),
    .seg(seg2), .an(an2), .frame_done(frame_done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
    end
  endtask

  // Checks one whole frame starting at the ON0 sample and ends at the next ON0 sample.
  // Optionally changes count_in after sample chg_idx.
  task automatic check_frame(input bit sel, input logic [6:0] u_seg, input logic [6:0] t_seg,
                             input logic [6:0] off_seg, input int chg_idx, input logic [3:0] chg_val);
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        exp_an = 2'b10; exp_seg = u_seg;
      end else if (i < 6) begin
        exp_an = 2'b11; exp_seg = off_seg;
      end else if (i < 10) begin
        exp_an = 2'b01; exp_seg = t_seg;
      end else begin
        exp_an = 2'b11; exp_seg = off_seg;
      end
      check("an", i, {5'b0, sel ? an2 : an}, {5'b0, exp_an});
      check("seg", i, sel ? seg2 : seg, exp_seg);
      check("frame_done", i, {6'b0, sel ? frame_done2 : frame_done}, {6'b0, (i == 0)});
      if (i == chg_idx) count_in = chg_val;
      tick();
    end
  endtask

  initial begin
    clear    = 1'b1;
    count_in = 4'd7;
    hold     = 1'b0;
    clear2   = 1'b1;
    count2   = 4'd0;
    hold2    = 1'b0;

    // Reset values with no clock edge yet.
    #2;
    check("rst_an", 0, {5'b0, an}, 7'b0000011);
    check("rst_seg", 0, seg, 7'b1111111);
    check("rst_fd", 0, {6'b0, frame_done}, 7'b0);
    check("rst2_seg", 0, seg2, 7'b0000000);
    check("rst2_an", 0, {5'b0, an2}, 7'b0000011);

    // Release between edges; first ON0 two edges later.
    #10;
    clear = 1'b0;
    tick();
    check("post_rst_an", 0, {5'b0, an}, 7'b0000011);
    check("post_rst_fd", 0, {6'b0, frame_done}, 7'b0);
    tick();

    // count 7: units 7, tens blanked.
    check_frame(1'b0, 7'b1111000, 7'b1111111, 7'b1111111, -1, 4'd0);
    count_in = 4'd13;
    check_frame(1'b0, 7'b1111000, 7'b1111111, 7'b1111111, -1, 4'd0);
    // count 13: units 3, tens 1.
    count_in = 4'd5;
    check_frame(1'b0, 7'b0110000, 7'b1111001, 7'b1111111, -1, 4'd0);
    // count 5, switched to 9 during ON1: this frame stays 5.
    check_frame(1'b0, 7'b0010010, 7'b1111111, 7'b1111111, 7, 4'd9);
    // hold raised after the boundary that captured 9.
    hold     = 1'b1;
    count_in = 4'd1;
    check_frame(1'b0, 7'b0010000, 7'b1111111, 7'b1111111, -1, 4'd0);
    count_in = 4'd6;
    check_frame(1'b0, 7'b0010000, 7'b1111111, 7'b1111111, -1, 4'd0);
    count_in = 4'd12;
    check_frame(1'b0, 7'b0010000, 7'b1111111, 7'b1111111, -1, 4'd0);
    count_in = 4'd15;
    hold     = 1'b0;
    check_frame(1'b0, 7'b0010000, 7'b1111111, 7'b1111111, -1, 4'd0);
    // hold dropped: 15 appears at the following boundary.
    check_frame(1'b0, 7'b0010010, 7'b1111001, 7'b1111111, -1, 4'd0);

    // Advance into ON1, then assert clear between edges.
    for (int i = 0; i < 6; i++) tick();
    check("pre_clr_an", 0, {5'b0, an}, 7'b0000001);
    #2;
    clear    = 1'b1;
    count_in = 4'd13;
    #1;
    check("clr_an", 0, {5'b0, an}, 7'b0000011);
    check("clr_seg", 0, seg, 7'b1111111);
    check("clr_fd", 0, {6'b0, frame_done}, 7'b0);
    #1;
    clear = 1'b0;
    tick();
    check("clr_blank_an", 0, {5'b0, an}, 7'b0000011);
    tick();
    check_frame(1'b0, 7'b0110000, 7'b1111001, 7'b1111111, -1, 4'd0);

    // Active-high, no leading-zero blanking, count 0.
    clear2 = 1'b0;
    tick();
    check("dut2_blank_an", 0, {5'b0, an2}, 7'b0000011);
    tick();
    check_frame(1'b1, 7'b0111111, 7'b0111111, 7'b0000000, -1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
